// File: rtl/pattern_rx.sv
// ---------------------------------------------------------------------------
// pattern_rx
//
// Serial receiver/decoder for the thermometer-pattern stream of the pattern
// transmitter. Bits arrive LSB first, one per enabled clock, and are
// assembled into 8-bit frames. Each frame is checked against the eight legal
// masks 2^(S+1)-1 (0x01 .. 0xFF), S is recovered, and a lock FSM tracks
// whether the link carries a stable legal pattern.
//
// Parameters:
//   LOCK_FRAMES  consecutive identical legal frames needed to lock (1..15)
//
// Ports:
//   clk      in   rising-edge clock, shared with the transmitter
//   clear    in   asynchronous active-high reset
//   en       in   sample enable; low = no bit taken, state holds
//   din      in   serial data, LSB of each frame first
//   word     out  [7:0] last complete frame
//   s_out    out  [2:0] decoded S of the last legal frame
//   valid    out  one-cycle pulse: a frame completed, word updated
//   error    out  one-cycle pulse with valid: frame is not a legal mask
//   locked   out  link locked onto a stable legal pattern
//   err_cnt  out  [7:0] saturating count of error pulses
//                 (only when PATTERN_RX_ERRCNT_EN is defined)
//
// Optional feature macro: PATTERN_RX_ERRCNT_EN
// ---------------------------------------------------------------------------
module pattern_rx #(
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       en,
    input  logic       din,
    output logic [7:0] word,
    output logic [2:0] s_out,
    output logic       valid,
    output logic       error,
    output logic       locked
`ifdef PATTERN_RX_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } state_t;

    logic [2:0] bcnt;
    logic [6:0] sh;
    logic [3:0] mcnt;
    logic [2:0] ls;
    state_t     state;

    logic       done;
    logic [7:0] frame;
    logic       legal;
    logic [2:0] n;
    logic [3:0] mcnt_inc;

    // The 8th bit is not stored in sh; it is taken straight from din on the
    // completing edge.
    assign done  = en && (bcnt == 3'd7);
    assign frame = {din, sh};

    // Legal masks are exactly the eight thermometer codes.
    always_comb begin
        legal = 1'b1;
        n     = 3'd0;
        case (frame)
            8'h01:   n = 3'd0;
            8'h03:   n = 3'd1;
            8'h07:   n = 3'd2;
            8'h0F:   n = 3'd3;
            8'h1F:   n = 3'd4;
            8'h3F:   n = 3'd5;
            8'h7F:   n = 3'd6;
            8'hFF:   n = 3'd7;
            default: legal = 1'b0;
        endcase
    end

    assign mcnt_inc = (mcnt == 4'd15) ? mcnt : mcnt + 4'd1;

    // Shift/assembly datapath and registered frame outputs.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            bcnt  <= 3'd0;
            sh    <= 7'd0;
            word  <= 8'h00;
            s_out <= 3'd0;
            valid <= 1'b0;
            error <= 1'b0;
        end else begin
            // Pulses drop on any edge that does not complete a frame,
            // including edges with en low.
            valid <= done;
            error <= done && !legal;
            if (en) begin
                for (int i = 0; i < 7; i++) begin
                    if (bcnt == 3'(i)) sh[i] <= din;
                end
                bcnt <= bcnt + 3'd1;
            end
            if (done) begin
                word <= frame;
                if (legal) s_out <= n;
            end
        end
    end

    // Lock FSM. mcnt counts consecutive legal frames with S == ls; locking
    // is evaluated on the updated count only while unlocked. A change of S
    // while locked always drops lock first.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= UNLOCKED;
            mcnt  <= 4'd0;
            ls    <= 3'd0;
        end else if (done) begin
            if (!legal) begin
                state <= UNLOCKED;
                mcnt  <= 4'd0;
            end else begin
                case (state)
                    UNLOCKED: begin
                        if (n == ls) begin
                            mcnt <= mcnt_inc;
                            if (int'(mcnt_inc) >= LOCK_FRAMES) state <= LOCKED;
                        end else begin
                            mcnt <= 4'd1;
                            ls   <= n;
                            if (LOCK_FRAMES <= 1) state <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (n != ls) begin
                            state <= UNLOCKED;
                            mcnt  <= 4'd1;
                            ls    <= n;
                        end
                    end
                    default: state <= UNLOCKED;
                endcase
            end
        end
    end

    assign locked = (state == LOCKED);

`ifdef PATTERN_RX_ERRCNT_EN
    // Saturating error counter; only clear resets it.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            err_cnt <= 8'h00;
        end else if (done && !legal && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    // Error counter not built.
`endif

endmodule

// File: tb/tb_pattern_rx.sv
module tb_pattern_rx;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       en = 1'b0;
    logic       din = 1'b0;
    logic [7:0] word, word1;
    logic [2:0] s_out, s_out1;
    logic       valid, valid1, error, error1, locked, locked1;
`ifdef PATTERN_RX_ERRCNT_EN
    logic [7:0] err_cnt, err_cnt1;
`endif

    int nchk = 0;
    int nerr = 0;
    int vcnt = 0;

    always #5 clk = ~clk;

    pattern_rx dut (
        .clk(clk), .clear(clear), .en(en), .din(din),
        .word(word), .s_out(s_out), .valid(valid), .error(error),
        .locked(locked)
`ifdef PATTERN_RX_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    // Second instance shares all inputs, checks single-frame locking.
    pattern_rx #(.LOCK_FRAMES(1)) dut1 (
        .clk(clk), .clear(clear), .en(en), .din(din),
        .word(word1), .s_out(s_out1), .valid(valid1), .error(error1),
        .locked(locked1)
`ifdef PATTERN_RX_ERRCNT_EN
        , .err_cnt(err_cnt1)
`endif
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one bit, let one edge sample it, land 1 time unit after the edge.
    task automatic send_bit(input logic b);
        en  = 1'b1;
        din = b;
        @(posedge clk);
        #1;
        vcnt += int'(valid);
    endtask

    task automatic idle(input int cyc);
        en = 1'b0;
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk);
            #1;
            vcnt += int'(valid);
        end
    endtask

    // Sends a whole frame; vcnt ends as the number of valid pulses seen.
    task automatic send_frame(input logic [7:0] w);
        vcnt = 0;
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_word", word, 8'h00);
        chk("rst_s", {5'd0, s_out}, 8'd0);
        chk("rst_valid", {7'd0, valid}, 8'd0);
        chk("rst_error", {7'd0, error}, 8'd0);
        chk("rst_locked", {7'd0, locked}, 8'd0);
        clear = 1'b0;

        // 0x01: S=0 matches reset ls -> mcnt=1, not yet locked with 2
        send_frame(8'h01);
        chk("f01_vcnt", 8'(vcnt), 8'd1);
        chk("f01_valid", {7'd0, valid}, 8'd1);
        chk("f01_word", word, 8'h01);
        chk("f01_s", {5'd0, s_out}, 8'd0);
        chk("f01_error", {7'd0, error}, 8'd0);
        chk("f01_locked", {7'd0, locked}, 8'd0);
        chk("f01_locked_lf1", {7'd0, locked1}, 8'd1);

        // 0x0F twice -> locked, S=3
        send_frame(8'h0F);
        chk("f0f_a_locked", {7'd0, locked}, 8'd0);
        chk("f0f_a_s", {5'd0, s_out}, 8'd3);
        send_frame(8'h0F);
        chk("f0f_b_locked", {7'd0, locked}, 8'd1);
        chk("f0f_b_s", {5'd0, s_out}, 8'd3);

        // 0x3F -> S changes, lock lost
        send_frame(8'h3F);
        chk("f3f_s", {5'd0, s_out}, 8'd5);
        chk("f3f_locked", {7'd0, locked}, 8'd0);

        // 0x55 illegal
        send_frame(8'h55);
        chk("f55_valid", {7'd0, valid}, 8'd1);
        chk("f55_error", {7'd0, error}, 8'd1);
        chk("f55_word", word, 8'h55);
        chk("f55_s", {5'd0, s_out}, 8'd5);
        chk("f55_locked", {7'd0, locked}, 8'd0);
`ifdef PATTERN_RX_ERRCNT_EN
        chk("f55_errcnt", err_cnt, 8'd1);
`endif

        // 3 bits of 0xFF, then clear mid-frame
        vcnt = 0;
        send_bit(1'b1);
        chk("pulse_end_valid", {7'd0, valid}, 8'd0);
        chk("pulse_end_error", {7'd0, error}, 8'd0);
        send_bit(1'b1);
        send_bit(1'b1);
        en = 1'b0;
        #2 clear = 1'b1;
        #1;
        chk("clr_word", word, 8'h00);
        chk("clr_s", {5'd0, s_out}, 8'd0);
        #1 clear = 1'b0;
`ifdef PATTERN_RX_ERRCNT_EN
        chk("clr_errcnt", err_cnt, 8'd0);
`endif
        chk("clr_novalid", 8'(vcnt), 8'd0);
        send_frame(8'h07);
        chk("f07_vcnt", 8'(vcnt), 8'd1);
        chk("f07_word", word, 8'h07);
        chk("f07_s", {5'd0, s_out}, 8'd2);
        chk("f07_error", {7'd0, error}, 8'd0);

        // 0x1F stretched by 5 idle cycles between bits 3 and 4
        vcnt = 0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        idle(5);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        chk("f1f_early_vcnt", 8'(vcnt), 8'd0);
        send_bit(1'b0);
        chk("f1f_vcnt", 8'(vcnt), 8'd1);
        chk("f1f_word", word, 8'h1F);
        chk("f1f_s", {5'd0, s_out}, 8'd4);

        // Top legal mask and a near-miss illegal one
        send_frame(8'hFF);
        chk("fff_s", {5'd0, s_out}, 8'd7);
        chk("fff_error", {7'd0, error}, 8'd0);
        send_frame(8'h80);
        chk("f80_error", {7'd0, error}, 8'd1);
        chk("f80_s", {5'd0, s_out}, 8'd7);
        chk("f80_locked", {7'd0, locked}, 8'd0);
`ifdef PATTERN_RX_ERRCNT_EN
        chk("f80_errcnt", err_cnt, 8'd1);
        for (int k = 0; k < 300; k++) send_frame(8'h00);
        chk("sat_errcnt", err_cnt, 8'hFF);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
